addrcalcsec_mul_sched: RTL
==========================

Name: addrcalcsec_mul_sched

Overview:
- Round-robin scheduler that shares one combinational pointer-bounds recompute unit (addrcalcsec_mul) between NREQ requesters, e.g. AGU ports and the capability-set path.
- Accepts requests over valid/ready, registers the winner into an issue stage that drives the shared unit, and captures the result in an output stage with backpressure.
- Returns each result tagged with its requester id.
- Sits between the address-generation issue ports and the single shared addrcalcsec_mul instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester id width, equal to clog2(NREQ)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- req_vld  in  NREQ  per-requester request valid
- req_A  in  NREQ*65  per-requester pointer operand (slice i = bits [65*i+64:65*i])
- req_B  in  NREQ*12  per-requester bounds/offset operand
- req_attr  in  NREQ*4  per-requester attributes
- req_rdy  out  NREQ  one-hot grant/accept
- u_A  out  65  to shared unit A
- u_B  out  12  to shared unit B
- u_attr  out  4  to shared unit attr
- u_res  in  65  from shared unit res (combinational)
- rsp_vld  out  1  result valid
- rsp_id  out  IDW  requester id of result
- rsp_res  out  65  result pointer
- rsp_clamp  out  1  exponent was forced to 0 (attr[3] && B[11:7] > A exponent field)
- rsp_rdy  in  1  consumer accepts result
- flush  in  1  discard all in-flight work
- busy  out  1  S1 or S2 valid

Behaviour:
- Reset (rst==0 at posedge):
  - s1_vld=0, s2_vld=0, rr_ptr=0.
  - rsp_vld=0, rsp_id=0, rsp_res=0, rsp_clamp=0.
  - u_A/u_B/u_attr registers=0, req_rdy=0, busy=0.
  - Reset mid-operation drops all in-flight requests; no response is produced for them.
- Pipeline: S1 (issue register driving u_*) -> S2 (output register driving rsp_*).
  - Latency: a request accepted at edge N gives rsp_vld=1 after edge N+1.
  - Throughput: 1 per cycle while rsp_rdy=1.
- Stall logic:
  - s2_adv = !s2_vld | rsp_rdy.
  - s1_adv = !s1_vld | s2_adv.
  - Requests are accepted only when s1_adv=1 and flush=0.
- Arbitration, combinational:
  - Winner is the first i with req_vld[i]=1, scanning from rr_ptr upward mod NREQ.
  - req_rdy = onehot(winner) when s1_adv && !flush && any req_vld; otherwise 0.
  - req_rdy may depend combinationally on req_vld; req_vld must not depend on req_rdy.
  - On acceptance, rr_ptr <= (winner+1) mod NREQ. With no acceptance, rr_ptr holds.
- S1 load: on acceptance, u_A/u_B/u_attr <= winner slices, s1_id <= winner, s1_vld <= 1.
  - If s1_adv and no acceptance, s1_vld <= 0.
  - If !s1_adv, S1 holds and u_* stay stable.
- S2 load: if s2_adv, then s2_vld <= s1_vld.
  - If s1_vld, also rsp_res <= u_res, rsp_id <= s1_id, rsp_clamp <= (u_attr[3] && u_B[11:7] > exponent field of u_A).
  - rsp_* hold while rsp_vld && !rsp_rdy.
- Simultaneous S2 drain and S1 refill in one edge is legal and needed for full throughput.
- flush=1 at an edge:
  - s1_vld <= 0, s2_vld <= 0, no acceptance that cycle (req_rdy=0).
  - rr_ptr holds; data registers may hold stale values.
  - flush wins over rsp_rdy.
- Full-pipe backpressure: with s1_vld=s2_vld=1 and rsp_rdy=0, req_rdy=0 and u_* are held constant.
- Wrap-around: rr_ptr = NREQ-1 wraps to 0. NREQ need not be a power of 2; rr_ptr never holds values >= NREQ.
- busy = s1_vld | s2_vld.

Test Plan:
- Reset then single request:
  - Hold rst=0 for 2 cycles: all outputs 0.
  - req_vld=4'b0100, req_A[2]=A0, req_B[2]=12'h385, rsp_rdy=1.
  - Expect req_rdy=4'b0100 in that cycle; rsp_vld=1 two edges later with rsp_id=2 and rsp_res equal to the unit output for (A0, 12'h385).
- Round-robin fairness:
  - req_vld=4'b1111 held for 8 cycles, rsp_rdy=1.
  - Grant order 0,1,2,3,0,1,2,3; 8 responses back-to-back with ids in the same order.
- Backpressure:
  - Stream on requester 1 with rsp_rdy=0 from cycle 3.
  - Exactly 2 requests are accepted, then req_rdy=0 and rsp_res is stable.
  - Raise rsp_rdy: results drain in order with none lost or duplicated.
- Clamp flag:
  - A exponent=5, B[11:7]=9, attr=4'b1000 -> rsp_clamp=1.
  - Same with attr=4'b0000 -> rsp_clamp=0.
- Flush mid-flight:
  - Accept 2 requests, assert flush one cycle with rsp_rdy=0.
  - Next cycle rsp_vld=0 and busy=0; rr_ptr is unchanged and the next grant follows it.
- Sync reset mid-stream:
  - Drop rst for 1 cycle while s1_vld=s2_vld=1.
  - Next cycle all valids are 0, rr_ptr=0, and the first grant after reset goes to the lowest-indexed active requester.

Source files
------------

// File: rtl/addrcalcsec_mul_sched.sv
// Round-robin scheduler sharing one combinational pointer-bounds recompute unit between
// NREQ requesters: issue register (S1) drives the unit, output register (S2) holds results.
module addrcalcsec_mul_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_vld,
  input  logic [NREQ*65-1:0]   req_A,
  input  logic [NREQ*12-1:0]   req_B,
  input  logic [NREQ*4-1:0]    req_attr,
  output logic [NREQ-1:0]      req_rdy,
  output logic [64:0]          u_A,
  output logic [11:0]          u_B,
  output logic [3:0]           u_attr,
  input  logic [64:0]          u_res,
  output logic                 rsp_vld,
  output logic [IDW-1:0]       rsp_id,
  output logic [64:0]          rsp_res,
  output logic                 rsp_clamp,
  input  logic                 rsp_rdy,
  input  logic                 flush,
  output logic                 busy
);

  // Exponent field of the pointer operand, directly below the tag bit.
  localparam int unsigned ExpLsb = 59;
  localparam int unsigned ExpW   = 5;
  localparam int unsigned PW     = IDW + 1;
  localparam logic [IDW:0] NreqW = PW'(NREQ);

  logic           s1_vld_q, s1_vld_d;
  logic           s2_vld_q, s2_vld_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;
  logic [64:0]    u_a_q, u_a_d;
  logic [11:0]    u_b_q, u_b_d;
  logic [3:0]     u_attr_q, u_attr_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [64:0]    rsp_res_q, rsp_res_d;
  logic           rsp_clamp_q, rsp_clamp_d;

  logic           s1_adv, s2_adv, accept, found;
  logic [IDW-1:0] win;
  logic [IDW:0]   scan_idx;
  logic [64:0]    sel_a;
  logic [11:0]    sel_b;
  logic [3:0]     sel_attr;
  logic           clamp;

  assign s2_adv = !s2_vld_q || rsp_rdy;
  assign s1_adv = !s1_vld_q || s2_adv;

  // Scan upward from rr_ptr_q, wrapping at NREQ (which need not be a power of two).
  always_comb begin
    win      = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      scan_idx = {1'b0, rr_ptr_q} + PW'(off);
      if (scan_idx >= NreqW) begin
        scan_idx = scan_idx - NreqW;
      end
      if (!found && req_vld[scan_idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = scan_idx[IDW-1:0];
      end
    end
  end

  assign accept = rst && s1_adv && !flush && found;

  always_comb begin
    req_rdy = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_rdy[i] = accept && (win == IDW'(i));
    end
  end

  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_attr = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        sel_a    = req_A[i*65 +: 65];
        sel_b    = req_B[i*12 +: 12];
        sel_attr = req_attr[i*4 +: 4];
      end
    end
  end

  assign clamp = u_attr_q[3] && (u_b_q[11:7] > u_a_q[ExpLsb+ExpW-1:ExpLsb]);

  always_comb begin
    s1_vld_d    = s1_vld_q;
    s2_vld_d    = s2_vld_q;
    rr_ptr_d    = rr_ptr_q;
    s1_id_d     = s1_id_q;
    u_a_d       = u_a_q;
    u_b_d       = u_b_q;
    u_attr_d    = u_attr_q;
    rsp_id_d    = rsp_id_q;
    rsp_res_d   = rsp_res_q;
    rsp_clamp_d = rsp_clamp_q;

    if (flush) begin
      s1_vld_d = 1'b0;
      s2_vld_d = 1'b0;
    end else begin
      if (s1_adv) begin
        s1_vld_d = accept;
      end
      if (s2_adv) begin
        s2_vld_d = s1_vld_q;
        if (s1_vld_q) begin
          rsp_res_d   = u_res;
          rsp_id_d    = s1_id_q;
          rsp_clamp_d = clamp;
        end
      end
    end

    if (accept) begin
      u_a_d    = sel_a;
      u_b_d    = sel_b;
      u_attr_d = sel_attr;
      s1_id_d  = win;
      rr_ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      rr_ptr_q    <= '0;
      s1_id_q     <= '0;
      u_a_q       <= '0;
      u_b_q       <= '0;
      u_attr_q    <= '0;
      rsp_id_q    <= '0;
      rsp_res_q   <= '0;
      rsp_clamp_q <= 1'b0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s2_vld_q    <= s2_vld_d;
      rr_ptr_q    <= rr_ptr_d;
      s1_id_q     <= s1_id_d;
      u_a_q       <= u_a_d;
      u_b_q       <= u_b_d;
      u_attr_q    <= u_attr_d;
      rsp_id_q    <= rsp_id_d;
      rsp_res_q   <= rsp_res_d;
      rsp_clamp_q <= rsp_clamp_d;
    end
  end

  assign u_A       = u_a_q;
  assign u_B       = u_b_q;
  assign u_attr    = u_attr_q;
  assign rsp_vld   = s2_vld_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_clamp = rsp_clamp_q;
  assign busy      = s1_vld_q || s2_vld_q;

endmodule
